// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between pipeline writeback, debug host and the 4x8 register file.
// The master modport is the surrounding system (pipeline, host, register file); slave is the arbiter.
interface regfile_write_arbiter_if;
    logic [1:0] WB_addr_write;
    logic [7:0] WB_data_write;
    logic       WB_sig_write;
    logic [1:0] HS_addr;
    logic [7:0] HS_data;
    logic       HS_valid;
    logic       HS_ready;
    logic [1:0] DM_addr_write;
    logic [7:0] DM_data_write;
    logic       DM_sig_write;
    logic       sig_stall;
    logic       sig_init_busy;

    modport master (
        output WB_addr_write, WB_data_write, WB_sig_write,
        output HS_addr, HS_data, HS_valid,
        input  HS_ready,
        input  DM_addr_write, DM_data_write, DM_sig_write,
        input  sig_stall, sig_init_busy
    );

    modport slave (
        input  WB_addr_write, WB_data_write, WB_sig_write,
        input  HS_addr, HS_data, HS_valid,
        output HS_ready,
        output DM_addr_write, DM_data_write, DM_sig_write,
        output sig_stall, sig_init_busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Single write-port owner for the 4x8 register file: post-reset clear, pipeline-priority
// arbitration against a one-entry host buffer, and a starvation stall request.
module regfile_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter logic [7:0]  CLEAR_VALUE  = 8'h00
) (
    input  logic                     sig_clk,
    input  logic                     sig_rst_n,
    regfile_write_arbiter_if.slave   bus
);
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PEND} state_t;

    state_t          r_state,    w_state_nxt;
    logic [AW-1:0]   r_clr_addr, w_clr_addr_nxt;
    logic [AW-1:0]   r_buf_addr, w_buf_addr_nxt;
    logic [DW-1:0]   r_buf_data, w_buf_data_nxt;
    logic [CW-1:0]   r_wait_cnt, w_wait_cnt_nxt;
    logic            r_stall,    w_stall_nxt;

    logic            w_dm_we;
    logic [AW-1:0]   w_dm_addr;
    logic [DW-1:0]   w_dm_data;
    logic [CW-1:0]   w_wait_inc;

    assign w_wait_inc = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + CW'(1);

    always_ff @(posedge sig_clk or negedge sig_rst_n) begin
        if (!sig_rst_n) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
            r_wait_cnt <= '0;
            r_stall    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_buf_addr <= w_buf_addr_nxt;
            r_buf_data <= w_buf_data_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_stall    <= w_stall_nxt;
        end
    end

    // Next state and the combinational write-port mux (pipeline path has no added latency).
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_buf_addr_nxt = r_buf_addr;
        w_buf_data_nxt = r_buf_data;
        w_wait_cnt_nxt = r_wait_cnt;
        w_stall_nxt    = r_stall;
        w_dm_we        = 1'b0;
        w_dm_addr      = bus.WB_addr_write;
        w_dm_data      = bus.WB_data_write;

        case (r_state)
            S_CLEAR: begin
                w_dm_we        = 1'b1;
                w_dm_addr      = r_clr_addr;
                w_dm_data      = CLEAR_VALUE;
                w_clr_addr_nxt = r_clr_addr + AW'(1);
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                w_dm_we = bus.WB_sig_write;
                if (bus.HS_valid) begin
                    w_buf_addr_nxt = bus.HS_addr;
                    w_buf_data_nxt = bus.HS_data;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = S_PEND;
                end
            end
            S_PEND: begin
                if (bus.WB_sig_write) begin
                    w_dm_we        = 1'b1;
                    w_wait_cnt_nxt = w_wait_inc;
                    w_stall_nxt    = (w_wait_inc >= LIMIT);
                end else begin
                    w_dm_we        = 1'b1;
                    w_dm_addr      = r_buf_addr;
                    w_dm_data      = r_buf_data;
                    w_wait_cnt_nxt = '0;
                    w_stall_nxt    = 1'b0;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    // Write enable is gated by reset so the file sees no write while reset is held.
    assign bus.DM_sig_write  = sig_rst_n & w_dm_we;
    assign bus.DM_addr_write = w_dm_addr;
    assign bus.DM_data_write = w_dm_data;
    assign bus.HS_ready      = (r_state == S_IDLE);
    assign bus.sig_init_busy = (r_state == S_CLEAR);
    assign bus.sig_stall     = r_stall;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural 4x8 register file model.
module tb_regfile_write_arbiter;
    logic       clk;
    logic       rst_n;
    logic [7:0] rf [4];
    int         tests;
    int         errors;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(
        .STARVE_LIMIT (8),
        .CLEAR_VALUE  (8'h00)
    ) dut (
        .sig_clk   (clk),
        .sig_rst_n (rst_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_ff @(posedge clk) begin
        if (bus.DM_sig_write) rf[bus.DM_addr_write] <= bus.DM_data_write;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.WB_addr_write = 2'd0;
        bus.WB_data_write = 8'h00;
        bus.WB_sig_write  = 1'b0;
        bus.HS_addr       = 2'd0;
        bus.HS_data       = 8'h00;
        bus.HS_valid      = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        tests += 4;
        if (bus.HS_ready !== 1'b0) begin errors++; $display("FAIL rst_hs_ready got %b exp 0", bus.HS_ready); end
        if (bus.sig_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", bus.sig_stall); end
        if (bus.sig_init_busy !== 1'b1) begin errors++; $display("FAIL rst_init_busy got %b exp 1", bus.sig_init_busy); end
        if (bus.DM_sig_write !== 1'b0) begin errors++; $display("FAIL rst_dm_we got %b exp 0", bus.DM_sig_write); end
        tick();
        tick();
    endtask

    // Release reset and walk the four clear writes; wb_on drives a conflicting pipeline write.
    task automatic test_clear(input bit wb_on);
        for (int i = 0; i < 4; i++) rf[i] = 8'hEE;
        bus.WB_sig_write  = wb_on;
        bus.WB_addr_write = 2'd0;
        bus.WB_data_write = 8'hFF;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests += 5;
            if (bus.DM_sig_write !== 1'b1) begin errors++; $display("FAIL clr_we[%0d] got %b exp 1", k, bus.DM_sig_write); end
            if (bus.DM_addr_write !== 2'(k)) begin errors++; $display("FAIL clr_addr[%0d] got %0d exp %0d", k, bus.DM_addr_write, k); end
            if (bus.DM_data_write !== 8'h00) begin errors++; $display("FAIL clr_data[%0d] got %h exp 00", k, bus.DM_data_write); end
            if (bus.sig_init_busy !== 1'b1) begin errors++; $display("FAIL clr_busy[%0d] got %b exp 1", k, bus.sig_init_busy); end
            if (bus.HS_ready !== 1'b0) begin errors++; $display("FAIL clr_hs_ready[%0d] got %b exp 0", k, bus.HS_ready); end
            tick();
        end
        bus.WB_sig_write = 1'b0;
        #1;
        tests += 3;
        if (bus.sig_init_busy !== 1'b0) begin errors++; $display("FAIL clr_busy_done got %b exp 0", bus.sig_init_busy); end
        if (bus.HS_ready !== 1'b1) begin errors++; $display("FAIL clr_hs_ready_done got %b exp 1", bus.HS_ready); end
        if (bus.DM_sig_write !== 1'b0) begin errors++; $display("FAIL clr_idle_we got %b exp 0", bus.DM_sig_write); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rf[i] !== 8'h00) begin errors++; $display("FAIL clr_rf[%0d] got %h exp 00", i, rf[i]); end
        end
    endtask

    task automatic test_host_write;
        bus.HS_addr  = 2'd2;
        bus.HS_data  = 8'hA5;
        bus.HS_valid = 1'b1;
        #1;
        tests++;
        if (bus.HS_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_idle got %b exp 1", bus.HS_ready); end
        tick();
        bus.HS_valid = 1'b0;
        #1;
        tests += 4;
        if (bus.HS_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_pend got %b exp 0", bus.HS_ready); end
        if (bus.DM_sig_write !== 1'b1) begin errors++; $display("FAIL hs_we got %b exp 1", bus.DM_sig_write); end
        if (bus.DM_addr_write !== 2'd2) begin errors++; $display("FAIL hs_addr got %0d exp 2", bus.DM_addr_write); end
        if (bus.DM_data_write !== 8'hA5) begin errors++; $display("FAIL hs_data got %h exp a5", bus.DM_data_write); end
        tick();
        #1;
        tests += 3;
        if (bus.HS_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_back got %b exp 1", bus.HS_ready); end
        if (bus.DM_sig_write !== 1'b0) begin errors++; $display("FAIL hs_we_after got %b exp 0", bus.DM_sig_write); end
        if (rf[2] !== 8'hA5) begin errors++; $display("FAIL hs_rf2 got %h exp a5", rf[2]); end
    endtask

    task automatic test_collision;
        bus.HS_addr  = 2'd1;
        bus.HS_data  = 8'h3C;
        bus.HS_valid = 1'b1;
        tick();
        bus.HS_valid      = 1'b0;
        bus.WB_sig_write  = 1'b1;
        bus.WB_addr_write = 2'd1;
        bus.WB_data_write = 8'h77;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests += 3;
            if (bus.DM_sig_write !== 1'b1 || bus.DM_addr_write !== 2'd1) begin
                errors++; $display("FAIL col_wb_we[%0d] got we=%b addr=%0d exp we=1 addr=1", k, bus.DM_sig_write, bus.DM_addr_write);
            end
            if (bus.DM_data_write !== 8'h77) begin errors++; $display("FAIL col_wb_data[%0d] got %h exp 77", k, bus.DM_data_write); end
            if (bus.sig_stall !== 1'b0) begin errors++; $display("FAIL col_stall[%0d] got %b exp 0", k, bus.sig_stall); end
            tick();
        end
        bus.WB_sig_write = 1'b0;
        #1;
        tests += 2;
        if (bus.DM_sig_write !== 1'b1 || bus.DM_addr_write !== 2'd1) begin
            errors++; $display("FAIL col_hs_we got we=%b addr=%0d exp we=1 addr=1", bus.DM_sig_write, bus.DM_addr_write);
        end
        if (bus.DM_data_write !== 8'h3C) begin errors++; $display("FAIL col_hs_data got %h exp 3c", bus.DM_data_write); end
        tick();
        tests += 3;
        if (rf[1] !== 8'h3C) begin errors++; $display("FAIL col_rf1 got %h exp 3c", rf[1]); end
        if (bus.sig_stall !== 1'b0) begin errors++; $display("FAIL col_stall_end got %b exp 0", bus.sig_stall); end
        if (bus.HS_ready !== 1'b1) begin errors++; $display("FAIL col_hs_ready got %b exp 1", bus.HS_ready); end
    endtask

    // Park a host write behind 8 pipeline writes; stall must rise on the 8th blocked edge.
    task automatic starve_setup(input logic [1:0] a, input logic [7:0] d);
        bus.HS_addr  = a;
        bus.HS_data  = d;
        bus.HS_valid = 1'b1;
        tick();
        bus.HS_valid      = 1'b0;
        bus.WB_sig_write  = 1'b1;
        bus.WB_addr_write = 2'd0;
        bus.WB_data_write = 8'h11;
        for (int k = 0; k < 8; k++) begin
            #1;
            tests++;
            if (bus.sig_stall !== 1'b0) begin errors++; $display("FAIL starve_early[%0d] got %b exp 0", k, bus.sig_stall); end
            tick();
        end
        #1;
        tests += 2;
        if (bus.sig_stall !== 1'b1) begin errors++; $display("FAIL starve_stall got %b exp 1", bus.sig_stall); end
        if (bus.DM_data_write !== 8'h11) begin errors++; $display("FAIL starve_wb_data got %h exp 11", bus.DM_data_write); end
    endtask

    task automatic test_starve;
        starve_setup(2'd3, 8'h5A);
        bus.WB_sig_write = 1'b0;
        #1;
        tests += 3;
        if (bus.DM_sig_write !== 1'b1 || bus.DM_addr_write !== 2'd3) begin
            errors++; $display("FAIL starve_drain got we=%b addr=%0d exp we=1 addr=3", bus.DM_sig_write, bus.DM_addr_write);
        end
        if (bus.DM_data_write !== 8'h5A) begin errors++; $display("FAIL starve_drain_data got %h exp 5a", bus.DM_data_write); end
        if (bus.sig_stall !== 1'b1) begin errors++; $display("FAIL starve_stall_drain got %b exp 1", bus.sig_stall); end
        tick();
        tests += 4;
        if (bus.sig_stall !== 1'b0) begin errors++; $display("FAIL starve_stall_after got %b exp 0", bus.sig_stall); end
        if (bus.HS_ready !== 1'b1) begin errors++; $display("FAIL starve_hs_ready got %b exp 1", bus.HS_ready); end
        if (rf[3] !== 8'h5A) begin errors++; $display("FAIL starve_rf3 got %h exp 5a", rf[3]); end
        if (rf[0] !== 8'h11) begin errors++; $display("FAIL starve_rf0 got %h exp 11", rf[0]); end
    endtask

    task automatic test_reset_mid;
        starve_setup(2'd2, 8'h99);
        #2;
        rst_n = 1'b0;
        #1;
        tests += 3;
        if (bus.DM_sig_write !== 1'b0) begin errors++; $display("FAIL mid_rst_we got %b exp 0", bus.DM_sig_write); end
        if (bus.sig_stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got %b exp 0", bus.sig_stall); end
        if (bus.HS_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_hs_ready got %b exp 0", bus.HS_ready); end
        idle_inputs();
        tick();
        tick();
        test_clear(1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (bus.DM_sig_write !== 1'b0) begin errors++; $display("FAIL mid_ghost_we[%0d] got %b exp 0", k, bus.DM_sig_write); end
        end
        tests++;
        if (rf[2] !== 8'h00) begin errors++; $display("FAIL mid_rf2 got %h exp 00", rf[2]); end
    endtask

    task automatic test_wb_during_clear;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        test_clear(1'b1);
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        test_reset();
        test_clear(1'b0);
        test_host_write();
        test_collision();
        test_starve();
        test_reset_mid();
        test_wb_during_clear();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 4x8 register file.
- Arbitrates between the pipeline writeback stream and a debug host write channel; the pipeline always has priority.
- Zeroes all registers after reset with a clear sequencer.
- Raises a pipeline stall when a host write has been starved too long.
- Sits between the DM stage and the register file write port, and drives the file's DM_* write inputs.

Parameters:
- STARVE_LIMIT, 8: consecutive blocked cycles of a pending host write before sig_stall asserts; legal range 1..255.
- CLEAR_VALUE, 8'h00: value written to every register by the post-reset clear sequence.

Ports:
- sig_clk  in  1  system clock, rising edge.
- sig_rst_n  in  1  reset, asynchronous, active-low.
- WB_addr_write  in  2  pipeline writeback register address.
- WB_data_write  in  8  pipeline writeback data.
- WB_sig_write  in  1  pipeline writeback enable.
- HS_addr  in  2  host write register address.
- HS_data  in  8  host write data.
- HS_valid  in  1  host request valid.
- HS_ready  out  1  host request accepted when HS_valid&HS_ready at a rising edge.
- DM_addr_write  out  2  register file write address.
- DM_data_write  out  8  register file write data.
- DM_sig_write  out  1  register file write enable.
- sig_stall  out  1  request to freeze the pipeline front end.
- sig_init_busy  out  1  clear sequence in progress; pipeline must not issue writeback.

Behaviour:
Interface:
- One clock: sig_clk. Reset sig_rst_n is asynchronous, active-low.
- All state is in flops cleared by sig_rst_n.

Reset (sig_rst_n low) holds:
- state=CLEAR, clr_addr=0, buffer empty, wait_cnt=0.
- HS_ready=0, sig_stall=0, sig_init_busy=1.
- DM_sig_write forced 0 combinationally while sig_rst_n=0.

DM_* outputs:
- Combinational from current state and WB_* inputs; no added latency on the pipeline path.
- Register file forwarding must see a pipeline write in the same cycle.

States: CLEAR, IDLE, PEND.

CLEAR:
- Outputs: DM_sig_write=1, DM_addr_write=clr_addr, DM_data_write=CLEAR_VALUE, sig_init_busy=1, HS_ready=0.
- clr_addr increments each edge. After the edge writing address 3, go to IDLE.
- Exactly 4 edges after reset release: registers 0,1,2,3 written in order.
- WB_sig_write is ignored in CLEAR; a pipeline write there is dropped.

IDLE (buffer empty):
- HS_ready=1, sig_init_busy=0.
- DM_* mirrors WB_* (DM_sig_write=WB_sig_write).
- HS_valid=1 at an edge: capture HS_addr/HS_data into a one-entry buffer and go to PEND.
- A captured entry is never written in its capture cycle; earliest write is the next cycle.

PEND (buffer full):
- HS_ready=0.
- WB_sig_write=1: pipeline wins; DM_* mirrors WB_*; wait_cnt increments, saturating at 255.
- WB_sig_write=0: DM_* drives the buffered entry with DM_sig_write=1. At that edge the buffer empties, wait_cnt=0, go to IDLE.

sig_stall:
- Registered; set at the edge where wait_cnt becomes >= STARVE_LIMIT.
- Stays 1 while in PEND; clears at the drain edge.
- It is high for the cycle the host write issues and low the cycle after.

Same-address collision:
- Pipeline write to the same address as a pending host entry lands first; the host value lands later and is final.
- This is intended; it is host-debug semantics.

Reset mid-operation:
- Asynchronously discards the buffer and any stall, and restarts CLEAR from address 0.
- A host request accepted but not yet written is lost; the host must reissue.

No path produces two writes in one cycle; DM_sig_write is one source per cycle.

Test Plan:
1. Release reset, WB_sig_write=0, CLEAR_VALUE=8'h00:
   - DM writes 00 to addresses 0,1,2,3 on edges 1-4; sig_init_busy falls after edge 4.
   - HS_ready=1 on cycle 5.
2. IDLE, host HS_addr=2, HS_data=8'hA5, HS_valid pulse, no pipeline writes:
   - HS_ready drops next cycle; DM write addr 2 data A5 issues one cycle after acceptance.
   - HS_ready returns the following cycle.
3. Host pending addr 1 data 3C; WB_sig_write=1 addr 1 data 77 for 3 cycles, then 0:
   - DM writes 77 x3, then 3C; final reg1=3C; sig_stall stays 0 (3<8).
4. STARVE_LIMIT=8, host pending, WB_sig_write=1 continuously:
   - sig_stall rises after 8 blocked cycles.
   - Drop WB_sig_write one cycle later: host write issues that cycle; sig_stall low the next.
5. Assert sig_rst_n low while in PEND with sig_stall=1:
   - Immediately (async) DM_sig_write=0, sig_stall=0, HS_ready=0.
   - After release, full clear of 4 registers; buffered write never appears.
6. WB_sig_write=1 addr 0 data FF during CLEAR:
   - Ignored; DM writes CLEAR_VALUE to the clr_addr sequence unchanged.
